// File: rtl/spi_load_ctrl_if.sv
// Byte-stream input, memory-write port and status flags of the SPI boot loader.
// The master modport is the environment side; the slave modport is the loader.
interface spi_load_ctrl_if;
   logic        cs_active;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        mem_req;
   logic        mem_ready;
   logic [1:0]  mem_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        err_opcode;
   logic        err_overrun;
   logic        err_range;
   logic [15:0] word_count;

   modport master (
      output cs_active, rx_valid, rx_byte, mem_ready,
      input  mem_req, mem_sel, mem_addr, mem_wdata, busy,
             err_opcode, err_overrun, err_range, word_count
   );

   modport slave (
      input  cs_active, rx_valid, rx_byte, mem_ready,
      output mem_req, mem_sel, mem_addr, mem_wdata, busy,
             err_opcode, err_overrun, err_range, word_count
   );
endinterface

// File: rtl/spi_load_ctrl.sv
// Boot-time SPI loader: parses 0x01 (address) / 0x02 (data) commands from the
// SPI byte stream and issues 32-bit word writes into IMEM, DMEM or PIM SRAM.
module spi_load_ctrl #(
   parameter logic [31:0] IMEM_BASE = 32'h1000_0000,
   parameter logic [31:0] DMEM_BASE = 32'h1000_4000,
   parameter logic [31:0] SRAM_BASE = 32'h2000_0000
) (
   input logic            clk,
   input logic            rst_n,
   spi_load_ctrl_if.slave io_bus
);

   localparam logic [31:0] IMEM_SIZE = 32'h0000_4000;
   localparam logic [31:0] DMEM_SIZE = 32'h0000_4000;
   localparam logic [31:0] SRAM_SIZE = 32'h0000_1000;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_WRITE} state_t;

   state_t      r_state, w_state_next;
   logic [1:0]  r_byte_cnt;
   logic [23:0] r_shift;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [1:0]  r_sel;
   logic        r_err_opcode, r_err_overrun, r_err_range;
   logic [15:0] r_word_count;

   logic        w_rx;
   logic        w_last;
   logic        w_accept;
   logic [31:0] w_word;
   logic [1:0]  w_sel;

   assign w_rx     = io_bus.rx_valid & io_bus.cs_active;
   assign w_last   = w_rx && (r_byte_cnt == 2'd3);
   assign w_word   = {r_shift, io_bus.rx_byte};
   assign w_accept = (r_state == S_WRITE) && io_bus.mem_ready;

   // Subtraction form keeps each range test a single unsigned compare.
   always_comb begin
      if ((r_addr - IMEM_BASE) < IMEM_SIZE)      w_sel = 2'd0;
      else if ((r_addr - DMEM_BASE) < DMEM_SIZE) w_sel = 2'd1;
      else if ((r_addr - SRAM_BASE) < SRAM_SIZE) w_sel = 2'd2;
      else                                       w_sel = 2'd3;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // NOTE: next state is defaulted before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_rx && io_bus.rx_byte == 8'h01)      w_state_next = S_ADDR;
            else if (w_rx && io_bus.rx_byte == 8'h02) w_state_next = S_DATA;
         end
         S_ADDR: begin
            if (!io_bus.cs_active || w_last) w_state_next = S_IDLE;
         end
         S_DATA: begin
            if (!io_bus.cs_active)  w_state_next = S_IDLE;
            else if (w_last)        w_state_next = (w_sel != 2'd3) ? S_WRITE : S_IDLE;
         end
         S_WRITE: begin
            if (io_bus.mem_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_byte_cnt    <= '0;
         r_shift       <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_sel         <= 2'd3;
         r_err_opcode  <= 1'b0;
         r_err_overrun <= 1'b0;
         r_err_range   <= 1'b0;
         r_word_count  <= '0;
      end else begin
         if ((r_state == S_ADDR || r_state == S_DATA) && io_bus.cs_active) begin
            if (w_rx) begin
               r_byte_cnt <= r_byte_cnt + 2'd1;
               r_shift    <= {r_shift[15:0], io_bus.rx_byte};
            end
         end else begin
            r_byte_cnt <= '0;
         end

         if (r_state == S_IDLE && w_rx && io_bus.rx_byte > 8'h02)
            r_err_opcode <= 1'b1;

         if (r_state == S_ADDR && w_last)
            r_addr <= {w_word[31:2], 2'b00};

         if (r_state == S_DATA && w_last) begin
            r_wdata <= w_word;
            if (w_sel == 2'd3) begin
               r_err_range <= 1'b1;
               r_addr      <= r_addr + 32'd4;
            end else begin
               r_sel <= w_sel;
            end
         end

         if (r_state == S_WRITE && w_rx)
            r_err_overrun <= 1'b1;

         if (w_accept) begin
            r_addr <= r_addr + 32'd4;
            r_sel  <= 2'd3;
            if (r_word_count != 16'hFFFF) r_word_count <= r_word_count + 16'd1;
         end
      end
   end

   assign io_bus.mem_req     = (r_state == S_WRITE);
   assign io_bus.mem_sel     = r_sel;
   assign io_bus.mem_addr    = r_addr;
   assign io_bus.mem_wdata   = r_wdata;
   assign io_bus.busy        = (r_state != S_IDLE);
   assign io_bus.err_opcode  = r_err_opcode;
   assign io_bus.err_overrun = r_err_overrun;
   assign io_bus.err_range   = r_err_range;
   assign io_bus.word_count  = r_word_count;

endmodule

// File: tb/tb_spi_load_ctrl.sv
// Self-checking bench for spi_load_ctrl: directed command frames followed by
// randomized address/data traffic, checked against a region/address model.
module tb_spi_load_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_load_ctrl_if bus ();

   spi_load_ctrl dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus.slave)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state
   logic [31:0] m_addr;
   logic [15:0] m_count;
   logic        m_eop, m_eov, m_erg;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] region(input logic [31:0] a);
      if (a >= 32'h1000_0000 && a < 32'h1000_4000) return 2'd0;
      if (a >= 32'h1000_4000 && a < 32'h1000_8000) return 2'd1;
      if (a >= 32'h2000_0000 && a < 32'h2000_1000) return 2'd2;
      return 2'd3;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_byte  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic send_addr(input logic [31:0] a);
      send_byte(8'h01);
      send_word(a);
      m_addr = {a[31:2], 2'b00};
      check("addr_cmd_idle", bus.busy, 1'b0);
   endtask

   task automatic data_cmd(input logic [31:0] w, input int delay, input bit overrun);
      logic [1:0] s;
      s = region(m_addr);
      send_byte(8'h02);
      send_word(w);
      if (s != 2'd3) begin
         check("req_on", bus.mem_req, 1'b1);
         check("wr_addr", bus.mem_addr, m_addr);
         check("wr_sel", bus.mem_sel, s);
         check("wr_data", bus.mem_wdata, w);
         for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("req_hold", bus.mem_req, 1'b1);
            check("addr_hold", bus.mem_addr, m_addr);
            check("data_hold", bus.mem_wdata, w);
         end
         if (overrun) begin
            send_byte(8'h5A);
            m_eov = 1'b1;
            check("overrun_flag", bus.err_overrun, 1'b1);
            check("overrun_req", bus.mem_req, 1'b1);
            check("overrun_data", bus.mem_wdata, w);
            check("overrun_addr", bus.mem_addr, m_addr);
         end
         bus.mem_ready = 1'b1;
         @(negedge clk);
         bus.mem_ready = 1'b0;
         check("req_off", bus.mem_req, 1'b0);
         m_addr = m_addr + 32'd4;
         if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end else begin
         check("range_no_req", bus.mem_req, 1'b0);
         m_erg  = 1'b1;
         m_addr = m_addr + 32'd4;
         check("range_flag", bus.err_range, 1'b1);
      end
      check("word_count", bus.word_count, m_count);
      check("busy_after", bus.busy, 1'b0);
   endtask

   initial begin
      logic [31:0] a, base, span;
      int          pick;

      rst_n         = 1'b0;
      bus.cs_active = 1'b0;
      bus.rx_valid  = 1'b0;
      bus.rx_byte   = 8'h00;
      bus.mem_ready = 1'b0;
      m_addr = '0; m_count = '0; m_eop = 0; m_eov = 0; m_erg = 0;
      #12;
      check("rst_req", bus.mem_req, 1'b0);
      check("rst_sel", bus.mem_sel, 2'd3);
      check("rst_addr", bus.mem_addr, 32'h0);
      check("rst_wdata", bus.mem_wdata, 32'h0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_errs", {bus.err_opcode, bus.err_overrun, bus.err_range}, 3'b000);
      check("rst_count", bus.word_count, 16'h0);
      @(negedge clk);
      rst_n         = 1'b1;
      bus.cs_active = 1'b1;

      // Basic write, ready immediately
      send_addr(32'h1000_0008);
      data_cmd(32'hDEAD_BEEF, 0, 0);

      // IMEM/DMEM boundary crossing
      send_addr(32'h1000_3FFC);
      data_cmd(32'h0BAD_F00D, 0, 0);
      data_cmd(32'hCAFE_0001, 1, 0);

      // Backpressure: ready low for 5 cycles
      send_addr(32'h2000_0000);
      data_cmd(32'h1234_5678, 5, 0);

      // Unknown opcode, NOP, then a normal frame
      send_byte(8'h7F);
      m_eop = 1'b1;
      check("opcode_flag", bus.err_opcode, 1'b1);
      check("opcode_idle", bus.busy, 1'b0);
      send_byte(8'h00);
      check("nop_idle", bus.busy, 1'b0);
      send_addr(32'h1000_0101);
      data_cmd(32'hA5A5_5A5A, 0, 0);

      // Overrun during a pending write
      data_cmd(32'h7777_1111, 2, 1);

      // Chip select drops mid-frame
      send_byte(8'h02);
      send_byte(8'hAA);
      send_byte(8'hBB);
      check("partial_busy", bus.busy, 1'b1);
      @(negedge clk);
      bus.cs_active = 1'b0;
      @(negedge clk);
      check("cs_drop_idle", bus.busy, 1'b0);
      check("cs_drop_noreq", bus.mem_req, 1'b0);
      send_byte(8'h01);
      check("cs_low_ignored", bus.busy, 1'b0);
      bus.cs_active = 1'b1;
      data_cmd(32'h0102_0304, 0, 0);

      // Out-of-range target
      send_addr(32'h3000_0000);
      data_cmd(32'hFFFF_FFFF, 0, 0);

      // Randomized traffic
      for (int it = 0; it < 30; it++) begin
         pick = $urandom_range(0, 3);
         case (pick)
            0: begin base = 32'h1000_0000; span = 32'h4000; end
            1: begin base = 32'h1000_4000; span = 32'h4000; end
            2: begin base = 32'h2000_0000; span = 32'h1000; end
            default: begin base = $urandom; span = 32'h10; end
         endcase
         a = base + ($urandom % span);
         if ($urandom_range(0, 4) == 0) a = base + span - 32'd4;
         send_addr(a);
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            if ($urandom_range(0, 3) == 0) send_byte(8'h00);
            data_cmd($urandom, $urandom_range(0, 3), 1'b0);
         end
      end

      check("sticky_opcode", bus.err_opcode, m_eop);
      check("sticky_overrun", bus.err_overrun, m_eov);
      check("sticky_range", bus.err_range, m_erg);

      // Asynchronous reset while a write is pending
      send_addr(32'h1000_0000);
      send_byte(8'h02);
      send_word(32'h5555_AAAA);
      check("pre_reset_req", bus.mem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_req", bus.mem_req, 1'b0);
      check("async_rst_count", bus.word_count, 16'h0);
      check("async_rst_errs", {bus.err_opcode, bus.err_overrun, bus.err_range}, 3'b000);
      check("async_rst_sel", bus.mem_sel, 2'd3);
      m_addr = '0; m_count = '0; m_eop = 0; m_eov = 0; m_erg = 0;
      @(negedge clk);
      rst_n = 1'b1;
      send_addr(32'h2000_0FFC);
      data_cmd(32'h600D_600D, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
